// File: rtl/pkt_buf_tx_reader_if.sv
// Bus bundle for pkt_buf_tx_reader: descriptor input, packet-buffer read port, Ethernet-out stream.
interface pkt_buf_tx_reader_if #(
  parameter int unsigned PKTBUF_AWIDTH = 12,
  parameter int unsigned LEN_WIDTH     = 16
);
  logic                     desc_valid;
  logic                     desc_ready;
  logic [PKTBUF_AWIDTH-1:0] desc_addr;
  logic [LEN_WIDTH-1:0]     desc_len;

  logic                     pkt_buf_rden;
  logic [PKTBUF_AWIDTH-1:0] pkt_buf_rdaddress;
  logic                     pkt_buf_rd_valid;
  logic [519:0]             pkt_buf_rddata;

  logic [511:0]             out_data;
  logic                     out_valid;
  logic                     out_sop;
  logic                     out_eop;
  logic [5:0]               out_empty;
  logic                     out_almost_full;

  modport slave (
    input  desc_valid, desc_addr, desc_len, pkt_buf_rd_valid, pkt_buf_rddata, out_almost_full,
    output desc_ready, pkt_buf_rden, pkt_buf_rdaddress,
           out_data, out_valid, out_sop, out_eop, out_empty
  );

  modport master (
    output desc_valid, desc_addr, desc_len, pkt_buf_rd_valid, pkt_buf_rddata, out_almost_full,
    input  desc_ready, pkt_buf_rden, pkt_buf_rdaddress,
           out_data, out_valid, out_sop, out_eop, out_empty
  );
endinterface

// File: rtl/pkt_buf_tx_reader.sv
// Transmit-side packet-buffer reader: descriptors -> pipelined flit reads -> sop/eop/empty stream.
// Define PKT_BUF_TX_STATS_EN to add the stat_pkts / stat_flits saturating counters.
module pkt_buf_tx_reader #(
  parameter int unsigned PKTBUF_AWIDTH   = 12,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pkt_buf_tx_reader_if.slave bus,
  output logic               err_unexpected_rd
`ifdef PKT_BUF_TX_STATS_EN
  ,
  output logic [31:0]        stat_pkts,
  output logic [31:0]        stat_flits
`endif
);
  localparam int unsigned FL_W = LEN_WIDTH - 5;
  localparam int unsigned OP_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CR_W = OP_W + 1;
  localparam int unsigned TP_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned TC_W = TP_W + 1;

  typedef enum logic [0:0] {IDLE, ISSUE} state_e;
  typedef struct packed { logic sop; logic eop; logic [5:0] empty; } tag_t;
  typedef struct packed { logic [511:0] data; tag_t tag; } flit_t;

  state_e                   state_q, state_d;
  logic [PKTBUF_AWIDTH-1:0] addr_q, addr_d, rdaddr_q, rdaddr_d;
  logic [FL_W-1:0]          flits_left_q, flits_left_d;
  logic [5:0]               last_empty_q, last_empty_d;
  logic                     first_q, first_d;
  logic                     desc_ready_q, desc_ready_d, rden_q, rden_d;
  logic [CR_W-1:0]          credits_q, credits_d;

  tag_t                     tag_mem_q [MAX_OUTSTANDING];
  logic [TP_W-1:0]          tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [TC_W-1:0]          tag_cnt_q, tag_cnt_d;
  flit_t                    of_mem_q [FIFO_DEPTH];
  logic [OP_W-1:0]          of_wp_q, of_wp_d, of_rp_q, of_rp_d;
  logic [CR_W-1:0]          of_cnt_q, of_cnt_d;

  logic                     out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [511:0]             out_data_q, out_data_d;
  logic [5:0]               out_empty_q, out_empty_d;
  logic                     err_q, err_d;

  logic                     accept, issue, tag_pop, of_pop;
  tag_t                     tag_new;
  logic                     unused_rddata_hi;

  function automatic logic [TP_W-1:0] tag_inc(input logic [TP_W-1:0] p);
    return (p == TP_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TP_W'(1);
  endfunction

  assign accept  = desc_ready_q && bus.desc_valid;
  assign issue   = (state_q == ISSUE) && (credits_q != '0) && (tag_cnt_q != TC_W'(MAX_OUTSTANDING));
  assign tag_pop = bus.pkt_buf_rd_valid && (tag_cnt_q != '0);
  assign of_pop  = (of_cnt_q != '0) && !bus.out_almost_full;
  assign unused_rddata_hi = ^bus.pkt_buf_rddata[519:512];

  // Descriptor FSM: one read per cycle while credits and tags allow.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    flits_left_d = flits_left_q;
    last_empty_d = last_empty_q;
    first_d      = first_q;
    rden_d       = 1'b0;
    rdaddr_d     = rdaddr_q;
    case (state_q)
      IDLE: begin
        if (accept && (bus.desc_len != '0)) begin
          addr_d       = bus.desc_addr;
          flits_left_d = FL_W'((32'(bus.desc_len) + 32'd63) >> 6);
          last_empty_d = 6'(7'd64 - 7'(bus.desc_len[5:0]));
          first_d      = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          rden_d       = 1'b1;
          rdaddr_d     = addr_q;
          addr_d       = addr_q + PKTBUF_AWIDTH'(1);
          flits_left_d = flits_left_q - FL_W'(1);
          first_d      = 1'b0;
          if (flits_left_q == FL_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    desc_ready_d = (state_d == IDLE);
  end

  // Tag/flit FIFO bookkeeping, credits, output register and error flag.
  always_comb begin
    tag_new.sop   = first_q;
    tag_new.eop   = (flits_left_q == FL_W'(1));
    tag_new.empty = tag_new.eop ? last_empty_q : 6'd0;

    credits_d = credits_q;
    if (issue && !of_pop)      credits_d = credits_q - CR_W'(1);
    else if (!issue && of_pop) credits_d = credits_q + CR_W'(1);

    tag_wp_d  = issue   ? tag_inc(tag_wp_q) : tag_wp_q;
    tag_rp_d  = tag_pop ? tag_inc(tag_rp_q) : tag_rp_q;
    tag_cnt_d = tag_cnt_q + TC_W'(issue) - TC_W'(tag_pop);
    of_wp_d   = of_wp_q + OP_W'(tag_pop);
    of_rp_d   = of_rp_q + OP_W'(of_pop);
    of_cnt_d  = of_cnt_q + CR_W'(tag_pop) - CR_W'(of_pop);

    out_valid_d = of_pop;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_empty_d = out_empty_q;
    if (of_pop) begin
      out_data_d  = of_mem_q[of_rp_q].data;
      out_sop_d   = of_mem_q[of_rp_q].tag.sop;
      out_eop_d   = of_mem_q[of_rp_q].tag.eop;
      out_empty_d = of_mem_q[of_rp_q].tag.empty;
    end

    err_d = err_q || (bus.pkt_buf_rd_valid && (tag_cnt_q == '0));
  end

  // FIFO storage carries no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (issue)   tag_mem_q[tag_wp_q] <= tag_new;
    if (tag_pop) of_mem_q[of_wp_q]   <= {bus.pkt_buf_rddata[511:0], tag_mem_q[tag_rp_q]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rdaddr_q     <= '0;
      flits_left_q <= '0;
      last_empty_q <= '0;
      first_q      <= 1'b0;
      desc_ready_q <= 1'b0;
      rden_q       <= 1'b0;
      credits_q    <= CR_W'(FIFO_DEPTH);
      tag_wp_q     <= '0;
      tag_rp_q     <= '0;
      tag_cnt_q    <= '0;
      of_wp_q      <= '0;
      of_rp_q      <= '0;
      of_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rdaddr_q     <= rdaddr_d;
      flits_left_q <= flits_left_d;
      last_empty_q <= last_empty_d;
      first_q      <= first_d;
      desc_ready_q <= desc_ready_d;
      rden_q       <= rden_d;
      credits_q    <= credits_d;
      tag_wp_q     <= tag_wp_d;
      tag_rp_q     <= tag_rp_d;
      tag_cnt_q    <= tag_cnt_d;
      of_wp_q      <= of_wp_d;
      of_rp_q      <= of_rp_d;
      of_cnt_q     <= of_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      err_q        <= err_d;
    end
  end

  assign bus.desc_ready        = desc_ready_q;
  assign bus.pkt_buf_rden      = rden_q;
  assign bus.pkt_buf_rdaddress = rdaddr_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_sop           = out_sop_q;
  assign bus.out_eop           = out_eop_q;
  assign bus.out_empty         = out_empty_q;
  assign err_unexpected_rd     = err_q;

`ifdef PKT_BUF_TX_STATS_EN
  logic [31:0] stat_pkts_q, stat_pkts_d, stat_flits_q, stat_flits_d;

  // Saturating counters of emitted flits and packets.
  always_comb begin
    stat_pkts_d  = stat_pkts_q;
    stat_flits_d = stat_flits_q;
    if (out_valid_q && (stat_flits_q != '1))              stat_flits_d = stat_flits_q + 32'd1;
    if (out_valid_q && out_eop_q && (stat_pkts_q != '1))  stat_pkts_d  = stat_pkts_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts_q  <= '0;
      stat_flits_q <= '0;
    end else begin
      stat_pkts_q  <= stat_pkts_d;
      stat_flits_q <= stat_flits_d;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_flits = stat_flits_q;
`endif
endmodule

// File: tb/tb_pkt_buf_tx_reader.sv
// Directed bench for pkt_buf_tx_reader: packet-buffer memory model, descriptor-level flit model, per-cycle compare.
module tb_pkt_buf_tx_reader;
  localparam int AW    = 10;
  localparam int DEPTH = 16;
  localparam int RDLAT = 2;

  typedef struct {
    logic [511:0] d;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } exp_t;

  logic clk, rst_n, err_unexpected_rd;
`ifdef PKT_BUF_TX_STATS_EN
  logic [31:0] stat_pkts, stat_flits;
`endif

  pkt_buf_tx_reader_if #(.PKTBUF_AWIDTH(AW), .LEN_WIDTH(16)) bus ();

  pkt_buf_tx_reader #(
    .PKTBUF_AWIDTH(AW), .LEN_WIDTH(16), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .err_unexpected_rd(err_unexpected_rd)
`ifdef PKT_BUF_TX_STATS_EN
    ,
    .stat_pkts(stat_pkts),
    .stat_flits(stat_flits)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int infl    = 0;
  int stall_rds = 0;

  logic [AW-1:0] exp_rd_q[$];
  exp_t          exp_fl_q[$];
  logic [AW-1:0] rd_addr_log[$];
  int            rd_cyc[$];
  int            out_cyc[$];
  logic [5:0]    eop_empty_log[$];

  logic          pipe_v[RDLAT];
  logic [AW-1:0] pipe_a[RDLAT];
  int            inj_req = 0;
  int            inj_ack = 0;

  logic [AW-1:0] ea;
  exp_t          ef;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] payload(input logic [AW-1:0] a);
    logic [511:0] w;
    for (int j = 0; j < 16; j++) w[j*32 +: 32] = ((32'(a) << 16) | 32'(j)) ^ 32'h5A00_0000;
    return w;
  endfunction

  // A descriptor becomes flits: ceil(len/64) of them, sequential wrapped addresses.
  function automatic void model_push(input int a, input int len);
    int n;
    exp_t e;
    logic [AW-1:0] fa;
    n = (len + 63) / 64;
    for (int i = 0; i < n; i++) begin
      fa = AW'(a + i);
      exp_rd_q.push_back(fa);
      e.d     = payload(fa);
      e.sop   = (i == 0);
      e.eop   = (i == n - 1);
      e.empty = e.eop ? 6'((64 - len % 64) % 64) : 6'd0;
      exp_fl_q.push_back(e);
    end
  endfunction

  // Packet-buffer memory: answers every read RDLAT cycles later, in order.
  initial begin
    for (int i = 0; i < RDLAT; i++) begin pipe_v[i] = 1'b0; pipe_a[i] = '0; end
    bus.pkt_buf_rd_valid = 1'b0;
    bus.pkt_buf_rddata   = '0;
    forever begin
      @(negedge clk);
      bus.pkt_buf_rd_valid = pipe_v[RDLAT-1];
      bus.pkt_buf_rddata   = pipe_v[RDLAT-1] ? {8'hC3, payload(pipe_a[RDLAT-1])} : {520{1'b1}};
      if (inj_req != inj_ack) begin
        bus.pkt_buf_rd_valid = 1'b1;
        inj_ack = inj_req;
      end
      for (int i = RDLAT - 1; i > 0; i--) begin pipe_v[i] = pipe_v[i-1]; pipe_a[i] = pipe_a[i-1]; end
      pipe_v[0] = bus.pkt_buf_rden;
      pipe_a[0] = bus.pkt_buf_rdaddress;
    end
  end

  // Per-cycle compare of reads and output flits against the model queues.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) infl = 0;
    else begin
      if (bus.pkt_buf_rden) begin
        rd_addr_log.push_back(bus.pkt_buf_rdaddress);
        rd_cyc.push_back(cyc);
        infl++;
        if (bus.out_almost_full) stall_rds++;
        if (exp_rd_q.size() == 0) check("rd_extra", 1, 0);
        else begin
          ea = exp_rd_q.pop_front();
          check("rd_addr", 512'(bus.pkt_buf_rdaddress), 512'(ea));
        end
      end
      if (bus.out_valid) begin
        out_cyc.push_back(cyc);
        infl--;
        if (bus.out_eop) eop_empty_log.push_back(bus.out_empty);
        if (exp_fl_q.size() == 0) check("out_extra", 1, 0);
        else begin
          ef = exp_fl_q.pop_front();
          check("out_data", bus.out_data, ef.d);
          check("out_sop", 512'(bus.out_sop), 512'(ef.sop));
          check("out_eop", 512'(bus.out_eop), 512'(ef.eop));
          check("out_empty", 512'(bus.out_empty), 512'(ef.empty));
        end
      end
      check("credit_bound", 512'(infl > DEPTH), 0);
    end
  end

  task automatic send_desc(input int a, input int len, output int acc);
    acc = 0;
    bus.desc_valid = 1'b1;
    bus.desc_addr  = AW'(a);
    bus.desc_len   = 16'(len);
    for (int k = 0; k < 300; k++) begin
      if (bus.desc_ready) begin
        acc = cyc + 1;
        model_push(a, len);
        @(negedge clk);
        bus.desc_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("desc_timeout", 1, 0);
    bus.desc_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (exp_rd_q.size() == 0 && exp_fl_q.size() == 0 && !pipe_v[0] && !pipe_v[RDLAT-1])
        done = 1;
    end
    check("drain_timeout", 512'(done), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_rd_q.delete();
    exp_fl_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, r0, o0, e0, s0;
    rst_n = 1'b0;
    bus.desc_valid = 1'b0;
    bus.desc_addr  = '0;
    bus.desc_len   = '0;
    bus.out_almost_full = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_out_valid", 512'(bus.out_valid), 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_flags", 512'({bus.out_sop, bus.out_eop, bus.out_empty}), 0);
    check("rst_rden", 512'(bus.pkt_buf_rden), 0);
    check("rst_rdaddr", 512'(bus.pkt_buf_rdaddress), 0);
    check("rst_desc_ready", 512'(bus.desc_ready), 0);
    check("rst_err", 512'(err_unexpected_rd), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", 512'(bus.desc_ready), 1);

    // Single full flit.
    r0 = rd_addr_log.size(); o0 = out_cyc.size(); e0 = eop_empty_log.size();
    send_desc('h10, 64, acc);
    wait_drain();
    check("t1_nrd", 512'(rd_addr_log.size() - r0), 1);
    check("t1_rdaddr", 512'((rd_addr_log.size() > r0) ? rd_addr_log[r0] : '1), 'h10);
    check("t1_nout", 512'(out_cyc.size() - o0), 1);
    check("t1_latency", 512'((out_cyc.size() > o0) ? out_cyc[o0] - acc : -1), RDLAT + 3);
    check("t1_empty", 512'((eop_empty_log.size() > e0) ? eop_empty_log[e0] : 6'h3f), 0);

    // Three flits, 2-byte tail.
    r0 = rd_addr_log.size(); o0 = out_cyc.size(); e0 = eop_empty_log.size();
    send_desc('h20, 130, acc);
    wait_drain();
    check("t2_nrd", 512'(rd_addr_log.size() - r0), 3);
    check("t2_rd_back2back", 512'((rd_cyc.size() >= r0 + 3) ? rd_cyc[r0+2] - rd_cyc[r0] : -1), 2);
    check("t2_rd_last", 512'((rd_addr_log.size() >= r0 + 3) ? rd_addr_log[r0+2] : '0), 'h22);
    check("t2_nout", 512'(out_cyc.size() - o0), 3);
    check("t2_empty", 512'((eop_empty_log.size() > e0) ? eop_empty_log[e0] : 6'h0), 62);

    // Address wrap, fresh counters.
    do_reset();
    r0 = rd_addr_log.size(); o0 = out_cyc.size(); e0 = eop_empty_log.size();
    send_desc((1 << AW) - 1, 128, acc);
    wait_drain();
    check("t3_rd_max", 512'((rd_addr_log.size() >= r0 + 2) ? rd_addr_log[r0] : '0), (1 << AW) - 1);
    check("t3_rd_wrap", 512'((rd_addr_log.size() >= r0 + 2) ? rd_addr_log[r0+1] : '1), 0);
    check("t3_nout", 512'(out_cyc.size() - o0), 2);
    check("t3_empty", 512'((eop_empty_log.size() > e0) ? eop_empty_log[e0] : 6'h3f), 0);
`ifdef PKT_BUF_TX_STATS_EN
    check("t3_stat_pkts", 512'(stat_pkts), 1);
    check("t3_stat_flits", 512'(stat_flits), 2);
`endif

    // Zero-length descriptor is dropped; 65 bytes gives two flits.
    r0 = rd_addr_log.size(); o0 = out_cyc.size(); e0 = eop_empty_log.size();
    send_desc('h50, 0, acc);
    send_desc('h60, 65, acc);
    wait_drain();
    check("t4_nrd", 512'(rd_addr_log.size() - r0), 2);
    check("t4_rd_first", 512'((rd_addr_log.size() > r0) ? rd_addr_log[r0] : '0), 'h60);
    check("t4_nout", 512'(out_cyc.size() - o0), 2);
    check("t4_empty", 512'((eop_empty_log.size() > e0) ? eop_empty_log[e0] : 6'h0), 63);

    // Backpressure: 20-flit packet with the MAC stalled for 40 cycles.
    o0 = out_cyc.size(); s0 = stall_rds;
    bus.out_almost_full = 1'b1;
    send_desc('h100, 1280, acc);
    repeat (40) @(negedge clk);
    check("t5_stall_rds", 512'(stall_rds - s0), DEPTH);
    check("t5_no_out_stalled", 512'(out_cyc.size() - o0), 0);
    bus.out_almost_full = 1'b0;
    wait_drain();
    check("t5_nout", 512'(out_cyc.size() - o0), 20);

    // Read data with nothing outstanding is flagged and sticky.
    inj_req++;
    repeat (4) @(negedge clk);
    check("t6_err_set", 512'(err_unexpected_rd), 1);
    repeat (10) @(negedge clk);
    check("t6_err_sticky", 512'(err_unexpected_rd), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_err_rst", 512'(err_unexpected_rd), 0);
    exp_rd_q.delete();
    exp_fl_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_err_after_rst", 512'(err_unexpected_rd), 0);

    // Reset mid-packet: late read data is dropped and flagged.
    o0 = out_cyc.size();
    send_desc('h200, 640, acc);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_rd_q.delete();
    exp_fl_q.delete();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t7_err_late_data", 512'(err_unexpected_rd), 1);
    check("t7_no_out", 512'(out_cyc.size() - o0), 0);
    check("t7_ready", 512'(bus.desc_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
